// File: rtl/serial_mag_compare.sv
// serial_mag_compare
//   Sequential wide-operand magnitude comparator. Two operands of 4*NIBBLES
//   bits are accepted over a valid/ready handshake. They are compared one
//   4-bit slice per cycle, starting at the most-significant nibble. The scan
//   stops at the first unequal nibble.
//
//   Optional feature: define CMP_SIGNED_EN to add the signed_mode input. It
//   selects a two's-complement ordering, which inverts the sign bit of the
//   top nibble.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     block can accept operands (IDLE only)
//   a_in, b_in   operands, 4*NIBBLES bits
//   signed_mode  (CMP_SIGNED_EN only) latched with the operands
//   out_valid    result valid (DONE only)
//   out_ready    consumer accepts the result
//   agb/aeb/alb  A>B / A==B / A<B, registered, one-hot while out_valid
//   busy         high in SCAN or DONE
module serial_mag_compare #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
`ifdef CMP_SIGNED_EN
  input  logic                   signed_mode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   agb,
  output logic                   aeb,
  output logic                   alb,
  output logic                   busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] TOP = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
`ifdef CMP_SIGNED_EN
  logic          sgn_reg;
`endif

  // Current slice selected by idx.
  // In signed mode, the top nibble's bit 3 is flipped on both sides.
  // This turns the unsigned slice compare into a two's-complement compare.
  always_comb begin
    a_nib = 4'(a_reg >> {idx, 2'b00});
    b_nib = 4'(b_reg >> {idx, 2'b00});
`ifdef CMP_SIGNED_EN
    if (sgn_reg && (idx == TOP)) begin
      a_nib[3] = ~a_nib[3];
      b_nib[3] = ~b_nib[3];
    end
`endif
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      agb     <= 1'b0;
      aeb     <= 1'b0;
      alb     <= 1'b0;
`ifdef CMP_SIGNED_EN
      sgn_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            idx     <= TOP;
`ifdef CMP_SIGNED_EN
            sgn_reg <= signed_mode;
`endif
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (a_nib != b_nib) begin
            agb   <= (a_nib > b_nib);
            alb   <= (a_nib < b_nib);
            aeb   <= 1'b0;
            state <= DONE;
          end else if (idx == '0) begin
            agb   <= 1'b0;
            alb   <= 1'b0;
            aeb   <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            agb   <= 1'b0;
            aeb   <= 1'b0;
            alb   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// tb_serial_mag_compare
//   Directed bench for serial_mag_compare with NIBBLES=4.
//   It covers the reset values, equal operands, and differences in the top
//   and middle nibbles. It also covers result hold under backpressure with
//   a competing in_valid, an asynchronous reset during SCAN, and signed
//   mode when CMP_SIGNED_EN is defined.
module tb_serial_mag_compare;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
`ifdef CMP_SIGNED_EN
  logic        signed_mode = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        agb, aeb, alb, busy;

  int checks = 0;
  int errors = 0;

  serial_mag_compare #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
`ifdef CMP_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .agb       (agb),
    .aeb       (aeb),
    .alb       (alb),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a pair and let the next edge take it (edge 0).
  // Afterwards the inputs are scrambled to show they are no longer used.
  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    wait_edges(1);
    in_valid = 1'b0;
    a_in = ~a;
    b_in = ~b;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    wait_edges(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, busy, agb, aeb, alb} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_values: {rdy,ov,busy,agb,aeb,alb}=%b expected 100000",
               {in_ready, out_valid, busy, agb, aeb, alb});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_equal();
    accept(16'h1234, 16'h1234);
    wait_edges(3);
    checks++;
    if ({out_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL equal_edge3: {ov,busy}=%b expected 01", {out_valid, busy});
    end
    wait_edges(1);
    checks++;
    if ({out_valid, agb, aeb, alb} !== 4'b1010) begin
      errors++;
      $display("FAIL equal_edge4: {ov,agb,aeb,alb}=%b expected 1010",
               {out_valid, agb, aeb, alb});
    end
    release_result();
  endtask

  task automatic test_top_diff();
    accept(16'h8000, 16'h7FFF);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b001) begin
      errors++;
      $display("FAIL top_edge0: {rdy,ov,busy}=%b expected 001",
               {in_ready, out_valid, busy});
    end
    wait_edges(1);
    checks++;
    if ({out_valid, agb, aeb, alb} !== 4'b1100) begin
      errors++;
      $display("FAIL top_edge1: {ov,agb,aeb,alb}=%b expected 1100",
               {out_valid, agb, aeb, alb});
    end
    release_result();
  endtask

  task automatic test_mid_diff();
    accept(16'h12A0, 16'h12B0);
    wait_edges(2);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_edge2: out_valid=%b expected 0", out_valid);
    end
    wait_edges(1);
    checks++;
    if ({out_valid, agb, aeb, alb} !== 4'b1001) begin
      errors++;
      $display("FAIL mid_edge3: {ov,agb,aeb,alb}=%b expected 1001",
               {out_valid, agb, aeb, alb});
    end
    release_result();
    checks++;
    if ({in_ready, out_valid, busy, agb, aeb, alb} !== 6'b100000) begin
      errors++;
      $display("FAIL mid_release: {rdy,ov,busy,agb,aeb,alb}=%b expected 100000",
               {in_ready, out_valid, busy, agb, aeb, alb});
    end
  endtask

  task automatic test_back_to_back();
    accept(16'h0010, 16'h0020);
    wait_edges(3);
    checks++;
    if ({out_valid, agb, aeb, alb} !== 4'b1001) begin
      errors++;
      $display("FAIL hold_first: {ov,agb,aeb,alb}=%b expected 1001",
               {out_valid, agb, aeb, alb});
    end
    in_valid = 1'b1;
    a_in = 16'hFFFF;
    b_in = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      wait_edges(1);
      checks++;
      if ({in_ready, out_valid, agb, aeb, alb} !== 5'b01001) begin
        errors++;
        $display("FAIL hold_cycle%0d: {rdy,ov,agb,aeb,alb}=%b expected 01001",
                 i, {in_ready, out_valid, agb, aeb, alb});
      end
    end
    release_result();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL hold_bubble: {rdy,ov,busy}=%b expected 100",
               {in_ready, out_valid, busy});
    end
    wait_edges(1);
    in_valid = 1'b0;
    checks++;
    if ({in_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL hold_accept: {rdy,busy}=%b expected 01", {in_ready, busy});
    end
    wait_edges(1);
    checks++;
    if ({out_valid, agb, aeb, alb} !== 4'b1100) begin
      errors++;
      $display("FAIL hold_second: {ov,agb,aeb,alb}=%b expected 1100",
               {out_valid, agb, aeb, alb});
    end
    release_result();
  endtask

  task automatic test_async_reset();
    accept(16'h0F00, 16'h0E00);
    wait_edges(1);
    checks++;
    if ({out_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL rst_scan: {ov,busy}=%b expected 01", {out_valid, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, agb, aeb, alb} !== 6'b100000) begin
      errors++;
      $display("FAIL rst_async: {rdy,ov,busy,agb,aeb,alb}=%b expected 100000",
               {in_ready, out_valid, busy, agb, aeb, alb});
    end
    #2 rst_n = 1'b1;
    accept(16'h0001, 16'h0002);
    wait_edges(3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_edge3: out_valid=%b expected 0", out_valid);
    end
    wait_edges(1);
    checks++;
    if ({out_valid, agb, aeb, alb} !== 4'b1001) begin
      errors++;
      $display("FAIL rst_after_edge4: {ov,agb,aeb,alb}=%b expected 1001",
               {out_valid, agb, aeb, alb});
    end
    release_result();
  endtask

`ifdef CMP_SIGNED_EN
  task automatic test_signed();
    signed_mode = 1'b1;
    accept(16'h8000, 16'h0001);
    signed_mode = 1'b0;
    wait_edges(1);
    checks++;
    if ({out_valid, agb, aeb, alb} !== 4'b1001) begin
      errors++;
      $display("FAIL signed_on: {ov,agb,aeb,alb}=%b expected 1001",
               {out_valid, agb, aeb, alb});
    end
    release_result();
    signed_mode = 1'b0;
    accept(16'h8000, 16'h0001);
    signed_mode = 1'b1;
    wait_edges(1);
    checks++;
    if ({out_valid, agb, aeb, alb} !== 4'b1100) begin
      errors++;
      $display("FAIL signed_off: {ov,agb,aeb,alb}=%b expected 1100",
               {out_valid, agb, aeb, alb});
    end
    release_result();
    signed_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_equal();
    test_top_diff();
    test_mid_diff();
    test_back_to_back();
    test_async_reset();
`ifdef CMP_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
